// File: rtl/waffle_pkg.sv
// Shared constants and types for the waffle pixel path: default frame geometry,
// the packed frame type consumed by waffle_solver, and the write-side event bundle.
package waffle_pkg;

  localparam int DEF_ROWS  = 16;
  localparam int DEF_COLS  = 16;
  localparam int DEF_WIDTH = 32;

  typedef logic [DEF_ROWS-1:0][DEF_COLS-1:0][DEF_WIDTH-1:0] frame_t;

  // Outcome of a single write-port transfer, decoded once per cycle.
  typedef struct packed {
    logic commit;
    logic short_frame;
    logic long_frame;
  } wr_event_t;

  // Counter width for an index range of n entries (never zero bits).
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/waffle_frame_buffer_if.sv
// Pixel stream input and presented-frame output of the waffle frame buffer.
// The master side is the source/solver pair, the slave side is the buffer.
interface waffle_frame_buffer_if #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int WIDTH = 32
);

  logic                                 in_valid;
  logic                                 in_ready;
  logic [WIDTH-1:0]                     in_data;
  logic                                 in_last;
  logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] frame_out;
  logic                                 frame_valid;
  logic                                 frame_ack;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output frame_ack,
    input  in_ready,
    input  frame_out,
    input  frame_valid
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  frame_ack,
    output in_ready,
    output frame_out,
    output frame_valid
  );

endinterface

// File: rtl/waffle_bank_ctrl.sv
// Ping-pong bank bookkeeping: write/read bank pointers and the count of
// committed-but-unconsumed frames, updated by commits and solver acks.
module waffle_bank_ctrl (
  input  logic clk,
  input  logic rst_l,
  input  logic commit,
  input  logic ack,
  output logic wr_bank,
  output logic rd_bank,
  output logic in_ready,
  output logic frame_valid
);

  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [1:0] full_cnt_q, full_cnt_d;
  logic       ack_eff;

  always_comb begin
    // An ack with nothing presented is ignored.
    ack_eff    = ack && (full_cnt_q != 2'd0);
    wr_bank_d  = wr_bank_q ^ commit;
    rd_bank_d  = rd_bank_q ^ ack_eff;
    full_cnt_d = full_cnt_q;
    if (commit && !ack_eff) begin
      full_cnt_d = full_cnt_q + 2'd1;
    end else if (!commit && ack_eff) begin
      full_cnt_d = full_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_cnt_q <= 2'd0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      full_cnt_q <= full_cnt_d;
    end
  end

  // Both flags come from registered state only, so ack never reaches ready combinationally.
  assign wr_bank     = wr_bank_q;
  assign rd_bank     = rd_bank_q;
  assign in_ready    = (full_cnt_q != 2'd2);
  assign frame_valid = (full_cnt_q != 2'd0);

endmodule

// File: rtl/waffle_frame_buffer.sv
// Double-buffered frame store: loads a raster-order word stream into one bank
// while the other is presented whole to waffle_solver; checks frame length.
module waffle_frame_buffer
  import waffle_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_l,
  waffle_frame_buffer_if.slave  bus,
  output logic                  err_short,
  output logic                  err_long,
  output logic [15:0]           frames_done
);

  localparam int RW = idx_bits(ROWS);
  localparam int CW = idx_bits(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] bank_q [2];

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          err_short_q, err_short_d;
  logic          err_long_q, err_long_d;
  logic [15:0]   frames_done_q, frames_done_d;

  logic      wr_bank;
  logic      rd_bank;
  logic      in_ready;
  logic      frame_valid;
  logic      xfer;
  logic      at_end;
  logic      wr_en;
  wr_event_t ev;

  waffle_bank_ctrl u_bank_ctrl (
    .clk         (clk),
    .rst_l       (rst_l),
    .commit      (ev.commit),
    .ack         (bus.frame_ack),
    .wr_bank     (wr_bank),
    .rd_bank     (rd_bank),
    .in_ready    (in_ready),
    .frame_valid (frame_valid)
  );

  always_comb begin
    xfer           = bus.in_valid && in_ready;
    at_end         = (row_q == ROW_LAST) && (col_q == COL_LAST);
    ev.commit      = xfer && at_end && bus.in_last;
    ev.short_frame = xfer && !at_end && bus.in_last;
    ev.long_frame  = xfer && at_end && !bus.in_last;
    // A premature in_last word is dropped; an overlong final word lands in the uncommitted bank.
    wr_en          = xfer && !ev.short_frame;
  end

  always_comb begin
    row_d         = row_q;
    col_d         = col_q;
    err_short_d   = ev.short_frame;
    err_long_d    = ev.long_frame;
    frames_done_d = frames_done_q;
    if (ev.commit) begin
      frames_done_d = frames_done_q + 16'd1;
    end
    if (xfer) begin
      if (at_end || ev.short_frame) begin
        row_d = '0;
        col_d = '0;
      end else if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      row_q         <= '0;
      col_q         <= '0;
      err_short_q   <= 1'b0;
      err_long_q    <= 1'b0;
      frames_done_q <= 16'd0;
    end else begin
      row_q         <= row_d;
      col_q         <= col_d;
      err_short_q   <= err_short_d;
      err_long_q    <= err_long_d;
      frames_done_q <= frames_done_d;
    end
  end

  // Storage carries no reset; stale contents are masked by frame_valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank_q[wr_bank][row_q][col_q] <= bus.in_data;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.frame_valid = frame_valid;
  assign bus.frame_out   = bank_q[rd_bank];
  assign err_short       = err_short_q;
  assign err_long        = err_long_q;
  assign frames_done     = frames_done_q;

endmodule

// File: tb/tb_waffle_frame_buffer.sv
// Directed bench for waffle_frame_buffer: streams frames, keeps expected frames
// in a scoreboard queue and compares them against frame_out when acked.
module tb_waffle_frame_buffer;
  import waffle_pkg::*;

  localparam int ROWS  = 16;
  localparam int COLS  = 16;
  localparam int WIDTH = 32;
  localparam int NW    = ROWS * COLS;

  logic        clk;
  logic        rst_l;
  logic        err_short;
  logic        err_long;
  logic [15:0] frames_done;

  int checks;
  int errors;
  frame_t sb_q[$];
  frame_t tmp;

  waffle_frame_buffer_if #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) bus ();

  waffle_frame_buffer #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .bus         (bus),
    .err_short   (err_short),
    .err_long    (err_long),
    .frames_done (frames_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic frame_t mk(input int base);
    frame_t f;
    for (int i = 0; i < NW; i++) f[i / COLS][i % COLS] = WIDTH'(base + i);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_frame(input string tag, input frame_t exp);
    int bad;
    logic [31:0] ow, ew;
    bad = 0;
    for (int i = NW - 1; i >= 0; i--)
      if (bus.frame_out[i / COLS][i % COLS] !== exp[i / COLS][i % COLS]) bad = i;
    ow = bus.frame_out[bad / COLS][bad % COLS];
    ew = exp[bad / COLS][bad % COLS];
    checks++;
    assert (bus.frame_out === exp) else begin
      errors++;
      $error("FAIL %s: word %0d got %0h expected %0h", tag, bad, ow, ew);
    end
  endtask

  // Drives one word and returns 1 time unit after the edge that accepted it.
  task automatic send_word(input int data, input logic last);
    int waits;
    bus.in_valid = 1'b1;
    bus.in_data  = WIDTH'(data);
    bus.in_last  = last;
    waits = 0;
    @(negedge clk);
    while (!bus.in_ready && waits < 64) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 64) chk("ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int base, input int n, input int last_idx);
    for (int i = 0; i < n; i++) send_word(base + i, (i == last_idx));
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic ack_frame(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(bus.frame_valid), 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
    end else begin
      tmp = sb_q.pop_front();
      cmp_frame(tag, tmp);
    end
    bus.frame_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_ack = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_l         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.frame_ack = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
    chk("rst_err_short", 32'(err_short), 32'd0);
    chk("rst_err_long", 32'(err_long), 32'd0);
    chk("rst_frames_done", 32'(frames_done), 32'd0);
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;

    // First frame: value = index
    for (int i = 0; i < NW - 1; i++) send_word(i, 1'b0);
    chk("f0_valid_before_last", 32'(bus.frame_valid), 32'd0);
    send_word(NW - 1, 1'b1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    sb_q.push_back(mk(0));
    chk("f0_valid_after_last", 32'(bus.frame_valid), 32'd1);
    chk("f0_word_3_5", bus.frame_out[3][5], 32'd53);
    chk("f0_frames_done", 32'(frames_done), 32'd1);
    ack_frame("f0");
    chk("f0_valid_after_ack", 32'(bus.frame_valid), 32'd0);

    // Three frames without acking: the third must wait for a free bank
    send_frame(1000, NW, NW - 1);
    sb_q.push_back(mk(1000));
    chk("b2b_ready_one_full", 32'(bus.in_ready), 32'd1);
    send_frame(2000, NW, NW - 1);
    sb_q.push_back(mk(2000));
    chk("b2b_ready_two_full", 32'(bus.in_ready), 32'd0);
    chk("b2b_frames_done", 32'(frames_done), 32'd3);
    @(posedge clk);
    #1;
    chk("b2b_ready_still_low", 32'(bus.in_ready), 32'd0);
    ack_frame("b2b_f1");
    chk("b2b_ready_after_ack", 32'(bus.in_ready), 32'd1);
    send_frame(3000, NW, NW - 1);
    sb_q.push_back(mk(3000));
    ack_frame("b2b_f2");
    ack_frame("b2b_f3");
    chk("b2b_frames_done_end", 32'(frames_done), 32'd4);

    // Short frame: in_last on word 100
    send_frame(9900, 101, 100);
    chk("short_err_pulse", 32'(err_short), 32'd1);
    chk("short_no_valid", 32'(bus.frame_valid), 32'd0);
    chk("short_no_long", 32'(err_long), 32'd0);
    @(posedge clk);
    #1;
    chk("short_err_cleared", 32'(err_short), 32'd0);
    send_frame(4000, NW, NW - 1);
    sb_q.push_back(mk(4000));
    chk("short_next_word00", bus.frame_out[0][0], 32'd4000);
    chk("short_next_frames_done", 32'(frames_done), 32'd5);
    ack_frame("short_next");

    // Long frame: final word without in_last
    send_frame(8800, NW, -1);
    chk("long_err_pulse", 32'(err_long), 32'd1);
    chk("long_no_valid", 32'(bus.frame_valid), 32'd0);
    chk("long_frames_done", 32'(frames_done), 32'd5);
    @(posedge clk);
    #1;
    chk("long_err_cleared", 32'(err_long), 32'd0);
    send_frame(5000, NW, NW - 1);
    sb_q.push_back(mk(5000));
    chk("long_next_frames_done", 32'(frames_done), 32'd6);
    ack_frame("long_next");

    // Completion in the same cycle as ack
    send_frame(6000, NW, NW - 1);
    sb_q.push_back(mk(6000));
    for (int i = 0; i < NW - 1; i++) send_word(7000 + i, 1'b0);
    tmp = sb_q.pop_front();
    cmp_frame("sim_old_stable", tmp);
    bus.frame_ack = 1'b1;
    send_word(7000 + NW - 1, 1'b1);
    bus.frame_ack = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    sb_q.push_back(mk(7000));
    chk("sim_valid_held", 32'(bus.frame_valid), 32'd1);
    chk("sim_ready", 32'(bus.in_ready), 32'd1);
    chk("sim_frames_done", 32'(frames_done), 32'd8);
    ack_frame("sim_new");
    chk("sim_valid_after", 32'(bus.frame_valid), 32'd0);

    // Asynchronous reset mid-frame with a frame presented
    send_frame(8000, NW, NW - 1);
    chk("rst_mid_valid_before", 32'(bus.frame_valid), 32'd1);
    for (int i = 0; i < 128; i++) send_word(8500 + i, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst_l = 1'b0;
    #1;
    chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_mid_frame_valid", 32'(bus.frame_valid), 32'd0);
    chk("rst_mid_frames_done", 32'(frames_done), 32'd0);
    chk("rst_mid_err_short", 32'(err_short), 32'd0);
    chk("rst_mid_err_long", 32'(err_long), 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;
    send_frame(9000, NW, NW - 1);
    sb_q.push_back(mk(9000));
    chk("rst_after_word00", bus.frame_out[0][0], 32'd9000);
    chk("rst_after_frames_done", 32'(frames_done), 32'd1);
    ack_frame("rst_after");
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
